// File: rtl/ps2_pkg.sv
// Shared state encoding and prefix byte values for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus FILTER_LEN-sample glitch filter for one PS/2 line.
// Both lines use the same filter so data stays aligned with the filtered clock.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8,
  parameter bit GEN_FALL   = 1'b0
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Filtered level only moves after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    fall_d = GEN_FALL & filt_q & ~filt_d;
  end

  // Reset to the idle-high bus level.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign dout = filt_q;
  assign fall = fall_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame decode, E0/F0 prefix folding and a one-entry
// valid/ready holding register towards the keyboard-matrix logic.
module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_rel,
  output logic       rx_err,
  output logic       overrun
);
  import ps2_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_f, clk_fall, data_f, data_fall_unused;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN), .GEN_FALL(1'b1)) u_clk_filt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .din     (ps2_kbd_clk),
    .dout    (clk_f),
    .fall    (clk_fall)
  );

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN), .GEN_FALL(1'b0)) u_data_filt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .din     (ps2_kbd_data),
    .dout    (data_f),
    .fall    (data_fall_unused)
  );

  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_acc_q, par_acc_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          ext_pend_q, ext_pend_d;
  logic          rel_pend_q, rel_pend_d;
  logic          key_valid_q, key_valid_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_ext_q, key_ext_d;
  logic          key_rel_q, key_rel_d;
  logic          rx_err_q, rx_err_d;
  logic          overrun_q, overrun_d;
  logic          byte_done;

  // Frame FSM, timeout watchdog, prefix folding and holding register.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_acc_d   = par_acc_q;
    par_ok_d    = par_ok_q;
    tmo_cnt_d   = tmo_cnt_q;
    ext_pend_d  = ext_pend_q;
    rel_pend_d  = rel_pend_q;
    key_valid_d = key_valid_q & ~key_ready;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_rel_d   = key_rel_q;
    rx_err_d    = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;

    if (state_q == IDLE || clk_fall) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end

    if (clk_fall) begin
      case (state_q)
        IDLE: begin
          if (!data_f) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
            par_acc_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          shreg_d[bit_cnt_q] = data_f;
          par_acc_d          = par_acc_q ^ data_f;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            state_d = DATA;
          end
        end
        PARITY: begin
          par_ok_d = par_acc_q ^ data_f;
          state_d  = STOP;
        end
        STOP: begin
          if (data_f && par_ok_q) begin
            byte_done = 1'b1;
          end else begin
            rx_err_d   = 1'b1;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_cnt_q == TMO_LAST) begin
      rx_err_d   = 1'b1;
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
      tmo_cnt_d  = '0;
      state_d    = IDLE;
    end else begin
      state_d = state_q;
    end

    // An accept in the same cycle frees the slot, so the new event loads without overrun.
    if (byte_done) begin
      if (shreg_q == PS2_PREFIX_EXT) begin
        ext_pend_d = 1'b1;
      end else if (shreg_q == PS2_PREFIX_REL) begin
        rel_pend_d = 1'b1;
      end else begin
        ext_pend_d = 1'b0;
        rel_pend_d = 1'b0;
        if (!key_valid_q || key_ready) begin
          key_valid_d = 1'b1;
          key_code_d  = shreg_q;
          key_ext_d   = ext_pend_q;
          key_rel_d   = rel_pend_q;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end else begin
      byte_done = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'h00;
      par_acc_q   <= 1'b0;
      par_ok_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_rel_q   <= 1'b0;
      rx_err_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_acc_q   <= par_acc_d;
      par_ok_q    <= par_ok_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ext_pend_q  <= ext_pend_d;
      rel_pend_q  <= rel_pend_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_rel_q   <= key_rel_d;
      rx_err_q    <= rx_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_rel   = key_rel_q;
  assign rx_err    = rx_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: PS/2 frames driven on the pins, results
// compared with a byte-level model of prefix folding and error handling.
module tb_ps2_kbd_rx;

  localparam int FL = 4;
  localparam int TMO = 2000;
  localparam int H = 40;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic key_ready = 1'b1;
  logic key_valid, key_ext, key_rel, rx_err, overrun;
  logic [7:0] key_code;

  ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_kbd_clk  (ps2_clk),
    .ps2_kbd_data (ps2_data),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_rel      (key_rel),
    .rx_err       (rx_err),
    .overrun      (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  int err_cyc = 0;
  int kv_rise_cyc = 0;
  int stop_cyc = 0;
  int exp_err = 0;
  logic kv_prev = 1'b0;
  logic m_ext = 1'b0;
  logic m_rel = 1'b0;
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Observer: accepted events as {ext, rel, code}, plus pulse counts and timestamps.
  always @(negedge clk_sys) begin
    if (key_valid && key_ready) obs_q.push_back({key_ext, key_rel, key_code});
    if (key_valid && !kv_prev) kv_rise_cyc <= cyc;
    kv_prev <= key_valid;
    if (rx_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (overrun) ovr_cnt <= ovr_cnt + 1;
  end

  // Drive the first nbits bits of an 11-bit frame; bad_par inverts the odd parity bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_sys);
      ps2_data = fr[i];
      repeat (H) @(negedge clk_sys);
      ps2_clk = 1'b0;
      stop_cyc = cyc;
      repeat (H) @(negedge clk_sys);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * H) @(negedge clk_sys);
  endtask

  // Reference model: one received byte (ok=0 means a framing/parity error).
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
      exp_err++;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      exp_q.push_back({m_ext, m_rel, b});
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic send_and_model(input logic [7:0] b, input bit bad_par);
    send_frame(b, bad_par, 11);
    model_byte(b, !bad_par);
  endtask

  task automatic test_reset();
    logic [12:0] outs;
    reset_n = 1'b0;
    repeat (5) @(negedge clk_sys);
    outs = {key_valid, key_code, key_ext, key_rel, rx_err, overrun};
    for (int i = 0; i < 13; i++) begin
      total++;
      if (outs[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_out_bit%0d: got %b want 0", i, outs[i]);
      end
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
  endtask

  task automatic test_single();
    int e0;
    obs_q.delete();
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 11);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== 10'h01C) begin
      bad++;
      $display("FAIL single_1c: got n=%0d ev=%h want n=1 ev=01c", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 10'h3FF);
    end
    total++;
    if (kv_rise_cyc - stop_cyc != FL + 3) begin
      bad++;
      $display("FAIL single_latency: got %0d want %0d", kv_rise_cyc - stop_cyc, FL + 3);
    end
    total++;
    if (err_cnt != e0) begin
      bad++;
      $display("FAIL single_no_err: got %0d want %0d", err_cnt - e0, 0);
    end
  endtask

  task automatic test_prefix();
    obs_q.delete();
    exp_q.delete();
    send_and_model(8'hF0, 1'b0);
    send_and_model(8'h1C, 1'b0);
    send_and_model(8'hE0, 1'b0);
    send_and_model(8'hF0, 1'b0);
    send_and_model(8'h75, 1'b0);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL prefix_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL prefix_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_parity_err();
    int e0;
    obs_q.delete();
    e0 = err_cnt;
    send_and_model(8'hF0, 1'b0);
    send_and_model(8'h1C, 1'b1);
    total++;
    if (err_cnt != e0 + 1 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL parity_err: got errs=%0d events=%0d want errs=1 events=0", err_cnt - e0, obs_q.size());
    end
    total++;
    if (err_cyc - stop_cyc != FL + 3) begin
      bad++;
      $display("FAIL parity_err_latency: got %0d want %0d", err_cyc - stop_cyc, FL + 3);
    end
    send_and_model(8'h1C, 1'b0);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== 10'h01C) begin
      bad++;
      $display("FAIL parity_flags_cleared: got n=%0d ev=%h want n=1 ev=01c", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 10'h3FF);
    end
  endtask

  task automatic test_timeout();
    int e0, lf;
    obs_q.delete();
    e0 = err_cnt;
    send_frame(8'h00, 1'b0, 5);
    lf = stop_cyc;
    repeat (TMO - 200) @(negedge clk_sys);
    total++;
    if (err_cnt != e0) begin
      bad++;
      $display("FAIL timeout_early: got %0d errs want 0", err_cnt - e0);
    end
    repeat (400) @(negedge clk_sys);
    m_ext = 1'b0;
    m_rel = 1'b0;
    total++;
    if (err_cnt != e0 + 1) begin
      bad++;
      $display("FAIL timeout_err: got %0d errs want 1", err_cnt - e0);
    end
    total++;
    if (err_cyc - lf < TMO || err_cyc - lf > TMO + FL + 4) begin
      bad++;
      $display("FAIL timeout_delay: got %0d want %0d..%0d", err_cyc - lf, TMO, TMO + FL + 4);
    end
    send_frame(8'h29, 1'b0, 11);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== 10'h029) begin
      bad++;
      $display("FAIL timeout_recover: got n=%0d ev=%h want n=1 ev=029", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 10'h3FF);
    end
  endtask

  task automatic test_overrun();
    int o0;
    obs_q.delete();
    o0 = ovr_cnt;
    key_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 11);
    send_frame(8'h32, 1'b0, 11);
    total++;
    if (key_valid !== 1'b1 || key_code !== 8'h1C) begin
      bad++;
      $display("FAIL overrun_hold: got valid=%b code=%h want valid=1 code=1c", key_valid, key_code);
    end
    total++;
    if (ovr_cnt != o0 + 1) begin
      bad++;
      $display("FAIL overrun_pulse: got %0d want 1", ovr_cnt - o0);
    end
    @(posedge clk_sys);
    #1 key_ready = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    total++;
    if (key_valid !== 1'b0 || obs_q.size() != 1 || obs_q[0] !== 10'h01C) begin
      bad++;
      $display("FAIL overrun_accept: got valid=%b n=%0d want valid=0 n=1 ev=01c", key_valid, obs_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    key_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 4);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    total++;
    if (key_valid !== 1'b0 || key_code !== 8'h00 || rx_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got valid=%b code=%h err=%b ovr=%b want all 0", key_valid, key_code, rx_err, overrun);
    end
    reset_n = 1'b1;
    key_ready = 1'b1;
    m_ext = 1'b0;
    m_rel = 1'b0;
    repeat (3) @(negedge clk_sys);
    obs_q.delete();
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 11);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== 10'h01C || err_cnt != e0) begin
      bad++;
      $display("FAIL reset_mid_next: got n=%0d errs=%0d want n=1 ev=01c errs=0", obs_q.size(), err_cnt - e0);
    end
  endtask

  task automatic test_random();
    int e0, x0, r;
    logic [7:0] b;
    bit bp;
    obs_q.delete();
    exp_q.delete();
    e0 = err_cnt;
    x0 = exp_err;
    key_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else b = 8'($urandom);
      bp = ($urandom_range(0, 7) == 0);
      send_and_model(b, bp);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL random_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (err_cnt - e0 != exp_err - x0) begin
      bad++;
      $display("FAIL random_errs: got %0d want %0d", err_cnt - e0, exp_err - x0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity_err();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
